id_stage_hazard: RTL and testbench
==================================

Name: id_stage_hazard

Overview:
Parametrised instruction-decode stage for the MIPS pipeline. It contains a 32-entry register file with write-back bypass and immediate sign extension. It performs load-use hazard detection with stall and bubble insertion, and supports branch flush. It sits between the IF/ID register and EX. Its output registers form the ID/EX pipeline register, which carries a valid bit. Opcode decode stays in the external control unit, whose packed control word enters on ctrl_in.

Parameters:
DATA_W, 32, register/datapath width (must be >= 16)
PC_W, 32, width of the pc+4 value carried to EX
CTRL_W, 12, width of the packed control word from the control unit
MEMREAD_BIT, 3, bit index of MemRead inside ctrl_in
BYPASS_EN, 1, 1 = same-cycle write-back data forwarded to reads; 0 = no bypass

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
in_valid  in  1  IF/ID holds a real instruction
instruction  in  32  instruction from IF/ID
in_pc  in  PC_W  pc+4 from IF/ID
ctrl_in  in  CTRL_W  control word decoded from instruction[31:26]
flush  in  1  branch taken; kill the instruction now in ID
wb_reg_write  in  1  write-back enable
wb_write_reg  in  5  write-back register index
wb_write_data  in  DATA_W  write-back data
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_ctrl  out  CTRL_W  registered control word
ex_pc  out  PC_W  registered pc+4
ex_read_data1  out  DATA_W  registered rs value
ex_read_data2  out  DATA_W  registered rt value
ex_extended  out  DATA_W  registered sign-extended instruction[15:0]
ex_rs, ex_rt, ex_rd  out  5 each  registered instruction[25:21], [20:16], [15:11]

Behaviour:
- Reset (async, any time, including mid-stall):
  - All ex_* outputs go to 0 and ex_valid to 0.
  - All 32 registers clear to 0.
  - stall is 0 while reset is high.
- Register file:
  - r0 reads as 0 always; writes to index 0 are ignored.
  - A write occurs on the rising edge when wb_reg_write=1 and wb_write_reg!=0.
  - Reads are combinational on rs/rt.
  - With BYPASS_EN=1, if wb_reg_write=1, wb_write_reg!=0 and the index matches a read index, the read returns wb_write_data in the same cycle.
  - With BYPASS_EN=0, the read returns the old value until after the edge.
- Extension: ex_extended = {(DATA_W-16){instruction[15]}, instruction[15:0]}.
- Load-use hazard (combinational):
  - hazard = in_valid & ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt!=0) & ((ex_rt==instruction[25:21]) | (ex_rt==instruction[20:16])).
  - stall = hazard & ~flush.
- ID/EX update on each rising edge, by priority:
  1. flush=1: ex_valid<=0, ex_ctrl<=0. Data fields are don't-care and are loaded normally.
  2. stall=1: bubble; ex_valid<=0, ex_ctrl<=0. IF/ID is held externally, so the same instruction is re-decoded next cycle.
  3. Otherwise: ex_valid<=in_valid. ex_ctrl<=ctrl_in if in_valid, else 0. All data and index fields load.
- A bubble clears ex_ctrl[MEMREAD_BIT], so a load-use stall lasts exactly one cycle.
- Back-to-back loads each get their own single-cycle check.
- Latency: ID to ID/EX is 1 cycle. Register write to read visibility is 0 cycles with bypass, 1 cycle without.
- Simultaneous flush and hazard: flush wins, stall=0, bubble inserted.
- Simultaneous wb write and reset: reset wins.

Test Plan:
1. Reset mid-run: with registers loaded, assert reset for 1 cycle -> all ex_* = 0, ex_valid=0, and a following read of r5 returns 0.
2. Bypass: BYPASS_EN=1, wb writes r8=0x0000_00AA in the same cycle ID decodes add with rs=8 -> ex_read_data1=0xAA next edge. BYPASS_EN=0 -> ex_read_data1=0 (old value).
3. Sign extend and r0: instruction[15:0]=0x8001 -> ex_extended=0xFFFF_8001. Write r0=0x1234, then read r0 -> 0.
4. Load-use: lw r9 in ID/EX (MemRead=1, ex_rt=9), ID holds add with rs=9 -> stall=1 for exactly 1 cycle, ex_valid=0 and ex_ctrl=0 after that edge, then add issues with ex_valid=1. Same sequence with rs=rt=0 after lw r0 -> no stall.
5. Flush priority: hazard condition as in scenario 4 plus flush=1 -> stall=0, and next edge ex_valid=0, ex_ctrl=0.
6. in_valid=0 with ctrl_in=0xFFF -> ex_valid=0, ex_ctrl=0. Also, a stale MemRead in ID/EX with ex_valid=0 never raises stall.

Source files
------------

// File: rtl/id_stage_hazard.sv
// MIPS instruction-decode stage: register file with write-back bypass, sign extension,
// load-use stall/bubble insertion, branch flush, and the ID/EX pipeline register.
module id_stage_hazard #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int CTRL_W      = 12,
    parameter int MEMREAD_BIT = 3,
    parameter int BYPASS_EN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [DATA_W-1:0] ex_extended,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd
);

    logic [DATA_W-1:0] regFile_q [32];
    logic [4:0]        rsIdx, rtIdx, rdIdx;
    logic              wbWriteEn;
    logic              hazard;
    logic [DATA_W-1:0] readData1, readData2, extended;
    logic [5:0]        unusedOpcode;

    logic              exValid_q, exValid_d;
    logic [CTRL_W-1:0] exCtrl_q, exCtrl_d;
    logic [PC_W-1:0]   exPc_q;
    logic [DATA_W-1:0] exData1_q, exData2_q, exExt_q;
    logic [4:0]        exRs_q, exRt_q, exRd_q;

    assign rsIdx        = instruction[25:21];
    assign rtIdx        = instruction[20:16];
    assign rdIdx        = instruction[15:11];
    assign unusedOpcode = instruction[31:26];
    assign wbWriteEn    = wb_reg_write && (wb_write_reg != 5'd0);
    assign extended     = DATA_W'($signed(instruction[15:0]));

    // r0 is hard-wired zero; the write-back value is forwarded only when bypass is enabled
    function automatic logic [DATA_W-1:0] readReg(input logic [4:0] idx);
        if (idx == 5'd0)
            return '0;
        if ((BYPASS_EN != 0) && wbWriteEn && (wb_write_reg == idx))
            return wb_write_data;
        return regFile_q[idx];
    endfunction

    always_comb begin
        readData1 = readReg(rsIdx);
        readData2 = readReg(rtIdx);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regFile_q[i] <= '0;
        end else if (wbWriteEn) begin
            regFile_q[wb_write_reg] <= wb_write_data;
        end
    end

    assign hazard = in_valid && exValid_q && exCtrl_q[MEMREAD_BIT] && (exRt_q != 5'd0) &&
                    ((exRt_q == rsIdx) || (exRt_q == rtIdx));
    assign stall  = hazard && !flush && !reset;

    // Flush and stall both turn the ID/EX slot into a bubble; data fields still load
    always_comb begin
        exValid_d = in_valid;
        exCtrl_d  = in_valid ? ctrl_in : '0;
        if (flush || stall) begin
            exValid_d = 1'b0;
            exCtrl_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exValid_q <= 1'b0;
            exCtrl_q  <= '0;
            exPc_q    <= '0;
            exData1_q <= '0;
            exData2_q <= '0;
            exExt_q   <= '0;
            exRs_q    <= '0;
            exRt_q    <= '0;
            exRd_q    <= '0;
        end else begin
            exValid_q <= exValid_d;
            exCtrl_q  <= exCtrl_d;
            exPc_q    <= in_pc;
            exData1_q <= readData1;
            exData2_q <= readData2;
            exExt_q   <= extended;
            exRs_q    <= rsIdx;
            exRt_q    <= rtIdx;
            exRd_q    <= rdIdx;
        end
    end

    assign ex_valid      = exValid_q;
    assign ex_ctrl       = exCtrl_q;
    assign ex_pc         = exPc_q;
    assign ex_read_data1 = exData1_q;
    assign ex_read_data2 = exData2_q;
    assign ex_extended   = exExt_q;
    assign ex_rs         = exRs_q;
    assign ex_rt         = exRt_q;
    assign ex_rd         = exRd_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Testbench for id_stage_hazard: a bypassing and a non-bypassing instance share stimulus
// and are checked against a register-array and pipeline-slot reference model.
module tb_id_stage_hazard;

    localparam logic [11:0] ADD_CTRL = 12'h021;
    localparam logic [11:0] LW_CTRL  = 12'h0C8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] in_pc;
    logic [11:0] ctrl_in;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;

    logic        stall1, exValid1, stall0, exValid0;
    logic [11:0] exCtrl1, exCtrl0;
    logic [31:0] exPc1, exRd1_1, exRd2_1, exExt1, exPc0, exRd1_0, exRd2_0, exExt0;
    logic [4:0]  exRs1, exRt1, exRd1, exRs0, exRt0, exRd0;

    int testsRun = 0;
    int testsFailed = 0;

    // reference model: architectural registers plus the contents of the ID/EX slot
    logic [31:0] mReg [32];
    logic        mValid;
    logic [11:0] mCtrl;
    logic [31:0] mPc, mA1, mB1, mA0, mB0, mExt;
    logic [4:0]  mRs, mRt, mRd;
    logic        expStall, obsStall1, obsStall0;

    always #5 clk = ~clk;

    id_stage_hazard #(.BYPASS_EN(1)) dutByp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .in_pc(in_pc), .ctrl_in(ctrl_in), .flush(flush), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .stall(stall1),
        .ex_valid(exValid1), .ex_ctrl(exCtrl1), .ex_pc(exPc1), .ex_read_data1(exRd1_1),
        .ex_read_data2(exRd2_1), .ex_extended(exExt1), .ex_rs(exRs1), .ex_rt(exRt1),
        .ex_rd(exRd1)
    );

    id_stage_hazard #(.BYPASS_EN(0)) dutNoByp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .in_pc(in_pc), .ctrl_in(ctrl_in), .flush(flush), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .stall(stall0),
        .ex_valid(exValid0), .ex_ctrl(exCtrl0), .ex_pc(exPc0), .ex_read_data1(exRd1_0),
        .ex_read_data2(exRd2_0), .ex_extended(exExt0), .ex_rs(exRs0), .ex_rt(exRt0),
        .ex_rd(exRd0)
    );

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {6'h23, rs, rt, imm};
    endfunction

    function automatic logic [31:0] refRead(input logic [4:0] idx, input bit byp);
        if (idx == 5'd0) return 32'd0;
        if (byp && wb_reg_write && wb_write_reg == idx) return wb_write_data;
        return mReg[idx];
    endfunction

    function automatic bit refHazard();
        return in_valid && mValid && mCtrl[3] && (mRt != 0) &&
               (mRt == instruction[25:21] || mRt == instruction[20:16]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
        mValid = 0; mCtrl = 0; mPc = 0; mA1 = 0; mB1 = 0; mA0 = 0; mB0 = 0;
        mExt = 0; mRs = 0; mRt = 0; mRd = 0;
    endtask

    // samples stall before the edge, advances the model, then lets the edge happen
    task automatic cycle();
        #1;
        expStall  = refHazard() && !flush;
        obsStall1 = stall1;
        obsStall0 = stall0;
        mValid = (flush || expStall) ? 1'b0 : in_valid;
        mCtrl  = (flush || expStall || !in_valid) ? 12'h000 : ctrl_in;
        mPc  = in_pc;
        mA1  = refRead(instruction[25:21], 1'b1);
        mB1  = refRead(instruction[20:16], 1'b1);
        mA0  = refRead(instruction[25:21], 1'b0);
        mB0  = refRead(instruction[20:16], 1'b0);
        mExt = {{16{instruction[15]}}, instruction[15:0]};
        mRs  = instruction[25:21];
        mRt  = instruction[20:16];
        mRd  = instruction[15:11];
        if (wb_reg_write && wb_write_reg != 0) mReg[wb_write_reg] = wb_write_data;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [11:0] c);
        in_valid = v; instruction = ins; ctrl_in = c; in_pc = in_pc + 32'd4;
        flush = 0; wb_reg_write = 0;
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 0; instruction = 0; in_pc = 0; ctrl_in = 0; flush = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;
        modelReset();
        #2;
        testsRun++;
        if ({stall1, exValid1, exCtrl1, exPc1, exRd1_1, exRd2_1, exExt1, exRs1, exRt1, exRd1} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs_byp: got valid=%0b ctrl=%h pc=%h expected all zero",
                     exValid1, exCtrl1, exPc1);
        end
        testsRun++;
        if ({stall0, exValid0, exCtrl0, exPc0, exRd1_0, exRd2_0, exExt0} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs_nobyp: got valid=%0b ctrl=%h expected all zero",
                     exValid0, exCtrl0);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset_midrun();
        applyStimulus(0, 0, 0);
        wb_reg_write = 1; wb_write_reg = 5; wb_write_data = 32'h55;
        cycle();
        applyStimulus(1, mk(2, 9, 16'h0004), LW_CTRL);
        cycle();
        applyStimulus(1, mk(9, 3, 16'h0000), ADD_CTRL);
        #1;
        testsRun++;
        if (stall1 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrun_stall_before_reset: got %0b expected 1", stall1);
        end
        reset = 1;
        #1;
        testsRun++;
        if ({stall1, exValid1, exCtrl1, exPc1, exRd1_1, exRd2_1, exExt1, exRs1, exRt1, exRd1} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_reset_outputs: got stall=%0b valid=%0b ctrl=%h rt=%0d expected zeros",
                     stall1, exValid1, exCtrl1, exRt1);
        end
        @(negedge clk);
        reset = 0;
        modelReset();
        applyStimulus(1, mk(5, 5, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (exRd1_1 !== 32'd0 || exRd1_0 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL midrun_r5_cleared: got %h/%h expected 0", exRd1_1, exRd1_0);
        end
    endtask

    task automatic test_bypass();
        applyStimulus(1, mk(8, 0, 16'h0000), ADD_CTRL);
        wb_reg_write = 1; wb_write_reg = 8; wb_write_data = 32'h0000_00AA;
        cycle();
        testsRun++;
        if (exRd1_1 !== 32'hAA || exRd1_1 !== mA1) begin
            testsFailed++;
            $display("[TB] FAIL bypass_on: got %h expected %h", exRd1_1, 32'hAA);
        end
        testsRun++;
        if (exRd1_0 !== 32'h0 || exRd1_0 !== mA0) begin
            testsFailed++;
            $display("[TB] FAIL bypass_off_old: got %h expected 0", exRd1_0);
        end
        applyStimulus(1, mk(8, 8, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (exRd1_0 !== 32'hAA || exRd2_0 !== 32'hAA || exRd2_1 !== 32'hAA) begin
            testsFailed++;
            $display("[TB] FAIL bypass_off_next: got %h/%h expected aa", exRd1_0, exRd2_0);
        end
    endtask

    task automatic test_sign_r0();
        applyStimulus(1, mk(1, 2, 16'h8001), ADD_CTRL);
        cycle();
        testsRun++;
        if (exExt1 !== 32'hFFFF_8001) begin
            testsFailed++;
            $display("[TB] FAIL sign_ext_neg: got %h expected ffff8001", exExt1);
        end
        applyStimulus(1, mk(1, 2, 16'h7FFF), ADD_CTRL);
        cycle();
        testsRun++;
        if (exExt1 !== 32'h0000_7FFF || exRd1 !== 5'd15) begin
            testsFailed++;
            $display("[TB] FAIL sign_ext_pos: got %h rd=%0d expected 00007fff rd=15", exExt1, exRd1);
        end
        applyStimulus(1, mk(0, 0, 16'h0000), ADD_CTRL);
        wb_reg_write = 1; wb_write_reg = 0; wb_write_data = 32'h1234;
        cycle();
        testsRun++;
        if (exRd1_1 !== 32'd0 || exRd2_1 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL r0_no_bypass: got %h/%h expected 0", exRd1_1, exRd2_1);
        end
        applyStimulus(1, mk(0, 0, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (exRd1_1 !== 32'd0 || exRd1_0 !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL r0_read: got %h/%h expected 0", exRd1_1, exRd1_0);
        end
    endtask

    task automatic test_load_use();
        applyStimulus(0, 0, 0);
        cycle();
        applyStimulus(1, mk(2, 9, 16'h0004), LW_CTRL);
        cycle();
        applyStimulus(1, mk(9, 3, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b1 || obsStall0 !== 1'b1 || exValid1 !== 1'b0 || exCtrl1 !== 12'h0) begin
            testsFailed++;
            $display("[TB] FAIL loaduse_bubble: got stall=%0b valid=%0b ctrl=%h expected 1 0 000",
                     obsStall1, exValid1, exCtrl1);
        end
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b0 || exValid1 !== 1'b1 || exCtrl1 !== ADD_CTRL || exRs1 !== 5'd9) begin
            testsFailed++;
            $display("[TB] FAIL loaduse_issue: got stall=%0b valid=%0b ctrl=%h rs=%0d expected 0 1 %h 9",
                     obsStall1, exValid1, exCtrl1, exRs1, ADD_CTRL);
        end
        applyStimulus(1, mk(2, 0, 16'h0004), LW_CTRL);
        cycle();
        applyStimulus(1, mk(0, 0, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b0 || exValid1 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL loaduse_r0: got stall=%0b valid=%0b expected 0 1", obsStall1, exValid1);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(0, 0, 0);
        cycle();
        applyStimulus(1, mk(2, 9, 16'h0000), LW_CTRL);
        cycle();
        applyStimulus(1, mk(9, 10, 16'h0000), LW_CTRL);
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b1 || exValid1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_first_stall: got stall=%0b valid=%0b expected 1 0", obsStall1, exValid1);
        end
        cycle();
        applyStimulus(1, mk(10, 4, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b1 || exValid1 !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_second_stall: got stall=%0b valid=%0b expected 1 0", obsStall1, exValid1);
        end
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b0 || exValid1 !== 1'b1 || exCtrl1 !== ADD_CTRL) begin
            testsFailed++;
            $display("[TB] FAIL b2b_issue: got stall=%0b valid=%0b ctrl=%h expected 0 1 %h",
                     obsStall1, exValid1, exCtrl1, ADD_CTRL);
        end
    endtask

    task automatic test_flush();
        applyStimulus(0, 0, 0);
        cycle();
        applyStimulus(1, mk(2, 9, 16'h0000), LW_CTRL);
        cycle();
        applyStimulus(1, mk(9, 3, 16'h0000), ADD_CTRL);
        flush = 1;
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b0 || exValid1 !== 1'b0 || exCtrl1 !== 12'h0) begin
            testsFailed++;
            $display("[TB] FAIL flush_priority: got stall=%0b valid=%0b ctrl=%h expected 0 0 000",
                     obsStall1, exValid1, exCtrl1);
        end
        flush = 0;
    endtask

    task automatic test_invalid();
        applyStimulus(0, mk(2, 9, 16'h0000), 12'hFFF);
        cycle();
        testsRun++;
        if (exValid1 !== 1'b0 || exCtrl1 !== 12'h0) begin
            testsFailed++;
            $display("[TB] FAIL invalid_in: got valid=%0b ctrl=%h expected 0 000", exValid1, exCtrl1);
        end
        applyStimulus(1, mk(9, 9, 16'h0000), ADD_CTRL);
        cycle();
        testsRun++;
        if (obsStall1 !== 1'b0 || exValid1 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stale_memread: got stall=%0b valid=%0b expected 0 1", obsStall1, exValid1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid      = ($urandom_range(3) != 0);
            instruction   = {6'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)), 16'($urandom)};
            ctrl_in       = 12'($urandom);
            in_pc         = $urandom;
            flush         = ($urandom_range(9) == 0);
            wb_reg_write  = $urandom_range(1);
            wb_write_reg  = 5'($urandom_range(4));
            wb_write_data = $urandom;
            cycle();
            testsRun++;
            if (obsStall1 !== expStall || obsStall0 !== expStall) begin
                testsFailed++;
                $display("[TB] FAIL rand_stall[%0d]: got %0b/%0b expected %0b", n, obsStall1, obsStall0, expStall);
            end
            testsRun++;
            if ({exValid1, exCtrl1} !== {mValid, mCtrl} || {exValid0, exCtrl0} !== {mValid, mCtrl}) begin
                testsFailed++;
                $display("[TB] FAIL rand_ctrl[%0d]: got %0b %h expected %0b %h", n, exValid1, exCtrl1, mValid, mCtrl);
            end
            if (mValid) begin
                testsRun++;
                if ({exPc1, exRd1_1, exRd2_1, exExt1, exRs1, exRt1, exRd1} !== {mPc, mA1, mB1, mExt, mRs, mRt, mRd} ||
                    {exRd1_0, exRd2_0} !== {mA0, mB0}) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_data[%0d]: got %h %h %h %h / %h %h expected %h %h %h %h / %h %h",
                             n, exPc1, exRd1_1, exRd2_1, exExt1, exRd1_0, exRd2_0, mPc, mA1, mB1, mExt, mA0, mB0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_bypass();
        test_sign_r0();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_invalid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
